// File: rtl/physics_pkg.sv
// Shared definitions for the collision scheduler.
//
// Contents:
//   - DEF_* : default values for the scheduler parameters
//   - sched_state_e : scheduler FSM state encoding
//   - idx_width() : index width for a table of n entries (never below 1)
package physics_pkg;

  localparam int unsigned DEF_NUM_POINTS    = 8;
  localparam int unsigned DEF_NUM_EDGES     = 16;
  localparam int unsigned DEF_POSITION_SIZE = 8;
  localparam int unsigned DEF_VELOCITY_SIZE = 8;
  localparam int unsigned DEF_TIMEOUT       = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } sched_state_e;

  // A one-entry table still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_index_counter.sv
// Nested point/edge index counter for the collision scheduler.
//
// The edge index is the inner loop and the point index is the outer loop.
// Neither index ever wraps by overflow. The edge index returns to zero only
// through an explicit clear or a point advance. The point index stops at
// NUM_POINTS-1. The last-flags come from equality compares, so
// non-power-of-two table sizes behave correctly.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clr_i         zero both indices (frame start)
//   edge_inc_i    step the edge index; after the last edge, wrap to the next point
//   pt_adv_i      abandon the remaining edges and move to the next point
//   pt_idx_o      current point index
//   edge_idx_o    current edge index
//   pt_last_o     point index equals NUM_POINTS-1
//   edge_last_o   edge index equals NUM_EDGES-1
module sched_index_counter
  import physics_pkg::*;
#(
  parameter int unsigned NUM_POINTS = DEF_NUM_POINTS,
  parameter int unsigned NUM_EDGES  = DEF_NUM_EDGES,
  localparam int unsigned PW = idx_width(NUM_POINTS),
  localparam int unsigned EW = idx_width(NUM_EDGES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          edge_inc_i,
  input  logic          pt_adv_i,
  output logic [PW-1:0] pt_idx_o,
  output logic [EW-1:0] edge_idx_o,
  output logic          pt_last_o,
  output logic          edge_last_o
);

  logic [PW-1:0] pt_q;
  logic [EW-1:0] edge_q;

  assign pt_last_o   = (pt_q == PW'(NUM_POINTS - 1));
  assign edge_last_o = (edge_q == EW'(NUM_EDGES - 1));
  assign pt_idx_o    = pt_q;
  assign edge_idx_o  = edge_q;

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // updates from the values that held before the clock edge, regardless of
  // block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q   <= '0;
      edge_q <= '0;
    end else if (clr_i) begin
      pt_q   <= '0;
      edge_q <= '0;
    end else if (pt_adv_i || edge_inc_i) begin
      if (pt_adv_i || edge_last_o) begin
        edge_q <= '0;
        // At the last point the FSM is leaving the scan, so hold the index.
        if (!pt_last_o) pt_q <= pt_q + PW'(1);
      end else begin
        edge_q <= edge_q + EW'(1);
      end
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Collision scheduler: walks every (point, edge) pair once per frame.
// An external combinational detector reports a crossing on hit_in. For the
// first hit of each point, the scheduler launches one collision-datapath
// operation. It then waits for the datapath result and strobes a point
// write-back. The remaining edges of that point are skipped.
//
// Optional feature: define COLLISION_SCHED_TIMEOUT_EN to bound the datapath
// wait to TIMEOUT cycles. On expiry the point is skipped and the sticky
// timeout_err_out flag is set.
//
// Ports:
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   start_in           one-cycle pulse that starts a frame (accepted only in IDLE)
//   busy_out           frame in progress
//   done_out           one-cycle pulse at frame end
//   pt_addr_out        point register-file read index
//   pt_pos_*_in        point position (read by the external detector)
//   pt_vel_*_in        point velocity (read by the external detector)
//   edge_addr_out      edge table read index
//   hit_in             detector result for the current pair
//   coll_valid_out     one-cycle datapath launch
//   coll_valid_in      datapath result-valid pulse
//   wb_valid_out       one-cycle point write-back strobe
//   wb_addr_out        write-back point index
//   hit_count_out      points resolved in the last frame
//   timeout_err_out    sticky datapath timeout flag (only with the macro)
module collision_scheduler
  import physics_pkg::*;
#(
  parameter int unsigned NUM_POINTS    = DEF_NUM_POINTS,
  parameter int unsigned NUM_EDGES     = DEF_NUM_EDGES,
  parameter int unsigned POSITION_SIZE = DEF_POSITION_SIZE,
  parameter int unsigned VELOCITY_SIZE = DEF_VELOCITY_SIZE,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
  localparam int unsigned PW = idx_width(NUM_POINTS),
  localparam int unsigned EW = idx_width(NUM_EDGES),
  localparam int unsigned HW = $clog2(NUM_POINTS) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [PW-1:0]            pt_addr_out,
  input  logic [POSITION_SIZE-1:0] pt_pos_x_in,
  input  logic [POSITION_SIZE-1:0] pt_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] pt_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] pt_vel_y_in,
  output logic [EW-1:0]            edge_addr_out,
  input  logic                     hit_in,
  output logic                     coll_valid_out,
  input  logic                     coll_valid_in,
  output logic                     wb_valid_out,
  output logic [PW-1:0]            wb_addr_out,
  output logic [HW-1:0]            hit_count_out
`ifdef COLLISION_SCHED_TIMEOUT_EN
  ,
  output logic                     timeout_err_out
`endif
);

  sched_state_e  state_q;
  logic          busy_q, done_q, coll_valid_q, wb_valid_q;
  logic [PW-1:0] wb_addr_q;
  logic [HW-1:0] hit_count_q;

  logic          cnt_clr, cnt_edge_inc, cnt_pt_adv;
  logic [PW-1:0] pt_idx;
  logic [EW-1:0] edge_idx;
  logic          pt_last, edge_last;
  logic          timeout_skip;

  // Point kinematics feed the external detector, not this block. TIMEOUT is
  // only consumed when the timeout feature is built in.
  logic unused_inputs;
  assign unused_inputs = ^{pt_pos_x_in, pt_pos_y_in, pt_vel_x_in, pt_vel_y_in}
                         ^ (TIMEOUT == 0);

`ifdef COLLISION_SCHED_TIMEOUT_EN
  localparam int unsigned TW = idx_width(TIMEOUT);
  logic [TW-1:0] timer_q;
  logic          timeout_err_q;

  // timer_q counts WAIT cycles already spent. Expiry fires on the TIMEOUT-th.
  assign timeout_skip = (state_q == ST_WAIT) && !coll_valid_in
                        && (timer_q == TW'(TIMEOUT - 1));
  assign timeout_err_out = timeout_err_q;
`else
  assign timeout_skip = 1'b0;
`endif

  sched_index_counter #(
    .NUM_POINTS (NUM_POINTS),
    .NUM_EDGES  (NUM_EDGES)
  ) u_index (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .clr_i       (cnt_clr),
    .edge_inc_i  (cnt_edge_inc),
    .pt_adv_i    (cnt_pt_adv),
    .pt_idx_o    (pt_idx),
    .edge_idx_o  (edge_idx),
    .pt_last_o   (pt_last),
    .edge_last_o (edge_last)
  );

  // Index control. The indices do not move in ISSUE or WAIT, so both
  // addresses stay stable while the datapath works.
  // NOTE: every always_comb output is given a default first. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    cnt_clr      = 1'b0;
    cnt_edge_inc = 1'b0;
    cnt_pt_adv   = 1'b0;
    case (state_q)
      ST_IDLE:  cnt_clr      = start_in;
      ST_SCAN:  cnt_edge_inc = !hit_in;
      ST_WAIT:  cnt_pt_adv   = timeout_skip;
      ST_WRITE: cnt_pt_adv   = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      coll_valid_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      hit_count_q  <= '0;
`ifdef COLLISION_SCHED_TIMEOUT_EN
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      coll_valid_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            busy_q      <= 1'b1;
            hit_count_q <= '0;
`ifdef COLLISION_SCHED_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit_in)                   state_q <= ST_ISSUE;
          else if (pt_last && edge_last) state_q <= ST_DONE;
        end
        ST_ISSUE: begin
          coll_valid_q <= 1'b1;
`ifdef COLLISION_SCHED_TIMEOUT_EN
          timer_q      <= '0;
`endif
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Results only count here. A pulse arriving in any other state is
          // dropped, so a stale result cannot trigger a second launch.
          if (coll_valid_in) begin
            state_q <= ST_WRITE;
`ifdef COLLISION_SCHED_TIMEOUT_EN
          end else if (timeout_skip) begin
            timeout_err_q <= 1'b1;
            state_q       <= pt_last ? ST_DONE : ST_SCAN;
          end else begin
            timer_q <= timer_q + TW'(1);
`endif
          end
        end
        ST_WRITE: begin
          wb_valid_q  <= 1'b1;
          wb_addr_q   <= pt_idx;
          hit_count_q <= hit_count_q + HW'(1);
          state_q     <= pt_last ? ST_DONE : ST_SCAN;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign coll_valid_out = coll_valid_q;
  assign wb_valid_out   = wb_valid_q;
  assign wb_addr_out    = wb_addr_q;
  assign hit_count_out  = hit_count_q;
  assign pt_addr_out    = pt_idx;
  assign edge_addr_out  = edge_idx;

endmodule
